// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the loadable up-counter and its receive-side
//   checker. The reference model function lives here so that the checker and
//   any bench scoreboard predict the counter with exactly the same rule.
//
//   Contents
//     CNT_W_DEFAULT  default counter width
//     MODEL_W        width of the generic model datapath (counters up to 32 b)
//     state_t        checker FSM state {IDLE, TRACK}
//     cnt_next()     next counter value: clear > load > increment, mod 2**w
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int          CNT_W_DEFAULT = 5;
  localparam int unsigned MODEL_W       = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Reference model of the counter for one clock edge. Operands are carried
  // at MODEL_W bits and the result is masked to the real width w, so one
  // function serves every counter width up to MODEL_W.
  function automatic logic [MODEL_W-1:0] cnt_next(
    input logic               clr_,
    input logic               load,
    input logic [MODEL_W-1:0] data,
    input logic [MODEL_W-1:0] cur,
    input int unsigned        w
  );
    logic [MODEL_W-1:0] mask;
    logic [MODEL_W-1:0] nxt;
    mask = (w >= MODEL_W) ? '1 : ((MODEL_W'(1) << w) - MODEL_W'(1));
    if (!clr_) begin
      nxt = '0;
    end else if (load) begin
      nxt = data;
    end else begin
      nxt = cur + MODEL_W'(1);
    end
    return nxt & mask;
  endfunction

endpackage : counter_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Event counter that increments by one per strobe and sticks at all-ones.
//   Used by counter_checker to count mismatches without ever wrapping back
//   to a value that would understate the damage.
//
//   Parameters
//     WIDTH    counter width
//   Ports
//     clk      clock
//     rst_     asynchronous active-low reset, clears the count
//     inc_i    increment strobe, one count per cycle it is high
//     count_o  current count, saturating at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             full;

  assign full = &count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && !full) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state is written only with <= so every flop samples the
  // pre-edge values of its neighbours regardless of process ordering.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
//   Receive-side monitor for the loadable up-counter. It watches the counter's
//   control inputs and its output, predicts the output one edge ahead, and
//   flags every divergence. Pure observer: it never drives the counter.
//
//   Operation
//     IDLE   no comparisons; the first clear or load makes the prediction
//            trustworthy and moves to TRACK.
//     TRACK  each edge compares cnt against the prediction made at the
//            previous edge. On a mismatch the next prediction is re-seeded
//            from the observed cnt, so one corrupted value costs one error
//            rather than a cascade.
//
//   Parameters
//     W      counter width (prediction wraps modulo 2**W)
//     ERR_W  width of the saturating mismatch counter
//
//   Ports
//     clk        checker clock, shared with the counter
//     rst_       asynchronous active-low reset of the checker only
//     clr_       counter's synchronous active-low clear
//     load       counter's load strobe
//     data       counter's load value
//     cnt        counter's observed output
//     tracking   high while predictions are valid and compared
//     err        registered one-cycle pulse per mismatch
//     fail       sticky: at least one mismatch since rst_
//     err_cnt    mismatch count, saturating at all-ones
//     exp_cnt    current prediction of cnt (registered)
//
//   Build option COUNTER_CHECKER_CAPTURE_EN adds
//     first_exp  prediction at the first mismatch since rst_
//     first_obs  observed cnt at the first mismatch since rst_
// -----------------------------------------------------------------------------
module counter_checker
  import counter_pkg::*;
#(
  parameter int W     = CNT_W_DEFAULT,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clr_,
  input  logic             load,
  input  logic [W-1:0]     data,
  input  logic [W-1:0]     cnt,
  output logic             tracking,
  output logic             err,
  output logic             fail,
  output logic [ERR_W-1:0] err_cnt,
  output logic [W-1:0]     exp_cnt
`ifdef COUNTER_CHECKER_CAPTURE_EN
  ,
  output logic [W-1:0]     first_exp,
  output logic [W-1:0]     first_obs
`endif
);

  state_t             state_q;
  state_t             state_d;
  logic [W-1:0]       exp_q;
  logic [W-1:0]       exp_d;
  logic               err_q;
  logic               err_d;
  logic               fail_q;
  logic               fail_d;

  logic               mismatch;
  logic               judge_err;
  logic [W-1:0]       model_base;
  logic [MODEL_W-1:0] model_next;
  logic [W-1:0]       pred;

  // ---------------------------------------------------------------------------
  // Comparison. An unknown cnt in simulation is always a mismatch; the
  // 4-state check has no hardware meaning and is left out of synthesis.
  // ---------------------------------------------------------------------------
  always_comb begin
    mismatch = (cnt != exp_q);
`ifndef SYNTHESIS
    if ($isunknown(cnt)) begin
      mismatch = 1'b1;
    end
`endif
  end

  assign judge_err = (state_q == TRACK) && mismatch;

  // ---------------------------------------------------------------------------
  // Reference model. After a mismatch the prediction continues from what the
  // counter actually shows, not from the stale prediction.
  // ---------------------------------------------------------------------------
  assign model_base = judge_err ? cnt : exp_q;
  assign model_next = cnt_next(clr_, load, MODEL_W'(data), MODEL_W'(model_base), W);
  assign pred       = model_next[W-1:0];

  // ---------------------------------------------------------------------------
  // FSM and prediction update
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    err_d   = 1'b0;
    fail_d  = fail_q;
    case (state_q)
      IDLE: begin
        // Before the first clear/load the counter's value is unknown to us;
        // only those two controls pin it to something predictable.
        if (!clr_ || load) begin
          state_d = TRACK;
          exp_d   = pred;
        end
      end
      TRACK: begin
        exp_d = pred;
        if (mismatch) begin
          err_d  = 1'b1;
          fail_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      exp_q   <= '0;
      err_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Mismatch counter
  // ---------------------------------------------------------------------------
  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst_    (rst_),
    .inc_i   (judge_err),
    .count_o (err_cnt)
  );

`ifdef COUNTER_CHECKER_CAPTURE_EN
  // ---------------------------------------------------------------------------
  // First-mismatch capture. fail_q is still low on the edge that judges the
  // first mismatch, which makes it the "not yet captured" flag for free.
  // ---------------------------------------------------------------------------
  logic [W-1:0] first_exp_q;
  logic [W-1:0] first_obs_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      first_exp_q <= '0;
      first_obs_q <= '0;
    end else if (judge_err && !fail_q) begin
      first_exp_q <= exp_q;
      first_obs_q <= cnt;
    end
  end

  assign first_exp = first_exp_q;
  assign first_obs = first_obs_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tracking = (state_q == TRACK);
  assign err      = err_q;
  assign fail     = fail_q;
  assign exp_cnt  = exp_q;

endmodule : counter_checker

// File: tb/tb_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_checker
//   Directed bench for counter_checker (W=5, ERR_W=8). Vectors are applied on
//   the falling edge and their hand-computed expected outputs are queued; a
//   separate monitor samples just after each rising edge and compares.
//   Build with COUNTER_CHECKER_CAPTURE_EN to also check first_exp/first_obs.
// -----------------------------------------------------------------------------
module tb_counter_checker;

  localparam int W     = 5;
  localparam int ERR_W = 8;

  typedef struct {
    string          name;
    logic           trk;
    logic           err;
    logic           fail;
    logic [ERR_W-1:0] ec;
    logic [W-1:0]   exp;
  } exp_t;

  logic             clk;
  logic             rst_;
  logic             clr_;
  logic             load;
  logic [W-1:0]     data;
  logic [W-1:0]     cnt;
  logic             tracking;
  logic             err;
  logic             fail;
  logic [ERR_W-1:0] err_cnt;
  logic [W-1:0]     exp_cnt;
`ifdef COUNTER_CHECKER_CAPTURE_EN
  logic [W-1:0]     first_exp;
  logic [W-1:0]     first_obs;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  counter_checker #(
    .W     (W),
    .ERR_W (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .clr_      (clr_),
    .load      (load),
    .data      (data),
    .cnt       (cnt),
    .tracking  (tracking),
    .err       (err),
    .fail      (fail),
    .err_cnt   (err_cnt),
    .exp_cnt   (exp_cnt)
`ifdef COUNTER_CHECKER_CAPTURE_EN
    ,
    .first_exp (first_exp),
    .first_obs (first_obs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic check_all(input string nm, input logic t, input logic e, input logic f,
                           input logic [ERR_W-1:0] ec, input logic [W-1:0] ex);
    check({nm, ".tracking"}, 32'(tracking), 32'(t));
    check({nm, ".err"},      32'(err),      32'(e));
    check({nm, ".fail"},     32'(fail),     32'(f));
    check({nm, ".err_cnt"},  32'(err_cnt),  32'(ec));
    check({nm, ".exp_cnt"},  32'(exp_cnt),  32'(ex));
  endtask

  // Apply one cycle of counter activity and queue the outputs expected after
  // the following rising edge.
  task automatic step(input string nm, input logic c, input logic l, input logic [W-1:0] d,
                      input logic [W-1:0] cv, input logic t, input logic e, input logic f,
                      input logic [ERR_W-1:0] ec, input logic [W-1:0] ex);
    exp_t x;
    @(negedge clk);
    clr_ = c;
    load = l;
    data = d;
    cnt  = cv;
    x.name = nm; x.trk = t; x.err = e; x.fail = f; x.ec = ec; x.exp = ex;
    sb_q.push_back(x);
  endtask

  // Wait (bounded) until the monitor has consumed every queued expectation.
  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic pulse_reset(input string nm);
    @(negedge clk);
    clr_ = 1'b1;
    load = 1'b0;
    #1 rst_ = 1'b0;
    #1;
    check_all(nm, 1'b0, 1'b0, 1'b0, '0, '0);
`ifdef COUNTER_CHECKER_CAPTURE_EN
    check({nm, ".first_exp"}, 32'(first_exp), 32'h0);
    check({nm, ".first_obs"}, 32'(first_obs), 32'h0);
`endif
    #1 rst_ = 1'b1;
  endtask

  // Monitor: compares after every rising edge for which a vector was queued.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        check_all(x.name, x.trk, x.err, x.fail, x.ec, x.exp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [W-1:0] e;
    logic [W-1:0] cv;
    logic [ERR_W-1:0] ec;

    rst_ = 1'b0;
    clr_ = 1'b1;
    load = 1'b0;
    data = '0;
    cnt  = '0;
    #3;
    check_all("reset", 1'b0, 1'b0, 1'b0, '0, '0);
    #1 rst_ = 1'b1;

    // Idle: no clear/load, random cnt -> never tracks, never errs.
    for (int i = 0; i < 6; i++) begin
      step("idle", 1'b1, 1'b0, W'($urandom_range(0, 31)), W'($urandom_range(0, 31)),
           1'b0, 1'b0, 1'b0, 8'h00, 5'h00);
    end
    drain();

    // Clear, load 1D, five increments through the 1F->00 wrap.
    step("good_clr",  1'b0, 1'b0, 5'h00, 5'h13, 1'b1, 1'b0, 1'b0, 8'h00, 5'h00);
    step("good_load", 1'b1, 1'b1, 5'h1D, 5'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'h1D);
    step("good_inc1", 1'b1, 1'b0, 5'h00, 5'h1D, 1'b1, 1'b0, 1'b0, 8'h00, 5'h1E);
    step("good_inc2", 1'b1, 1'b0, 5'h00, 5'h1E, 1'b1, 1'b0, 1'b0, 8'h00, 5'h1F);
    step("good_wrap", 1'b1, 1'b0, 5'h00, 5'h1F, 1'b1, 1'b0, 1'b0, 8'h00, 5'h00);
    step("good_inc4", 1'b1, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'h01);
    step("good_inc5", 1'b1, 1'b0, 5'h00, 5'h01, 1'b1, 1'b0, 1'b0, 8'h00, 5'h02);
    drain();

    // Same sequence with 0A seen in place of 1F: one error, re-seed to 0B.
    pulse_reset("rst_a");
    step("bad_clr",   1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'h00);
    step("bad_load",  1'b1, 1'b1, 5'h1D, 5'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'h1D);
    step("bad_inc1",  1'b1, 1'b0, 5'h00, 5'h1D, 1'b1, 1'b0, 1'b0, 8'h00, 5'h1E);
    step("bad_inc2",  1'b1, 1'b0, 5'h00, 5'h1E, 1'b1, 1'b0, 1'b0, 8'h00, 5'h1F);
    step("bad_hit",   1'b1, 1'b0, 5'h00, 5'h0A, 1'b1, 1'b1, 1'b1, 8'h01, 5'h0B);
    step("bad_after", 1'b1, 1'b0, 5'h00, 5'h0B, 1'b1, 1'b0, 1'b1, 8'h01, 5'h0C);
    step("bad_after2",1'b1, 1'b0, 5'h00, 5'h0C, 1'b1, 1'b0, 1'b1, 8'h01, 5'h0D);
    // Clear and load together in TRACK: clear wins, predict 00.
    step("clr_load",  1'b0, 1'b1, 5'h1F, 5'h0D, 1'b1, 1'b0, 1'b1, 8'h01, 5'h00);
    step("clr_next",  1'b1, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b1, 8'h01, 5'h01);
    drain();

    // Clear and load together straight out of IDLE.
    pulse_reset("rst_b");
    step("idle_cl",   1'b0, 1'b1, 5'h1F, 5'h17, 1'b1, 1'b0, 1'b0, 8'h00, 5'h00);
    step("idle_cl2",  1'b1, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'h01);
    drain();

    // 300 consecutive mismatches: err_cnt saturates at FF.
    pulse_reset("rst_c");
    step("sat_clr", 1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'h00);
    e = 5'h00;
    for (int i = 1; i <= 300; i++) begin
      cv = e + 5'd5;
      ec = (i > 255) ? 8'hFF : 8'(i);
      e  = cv + 5'd1;
      step("sat", 1'b1, 1'b0, 5'h00, cv, 1'b1, 1'b1, 1'b1, ec, e);
    end
    step("sat_end", 1'b1, 1'b0, 5'h00, e, 1'b1, 1'b0, 1'b1, 8'hFF, e + 5'd1);
    drain();

    // Asynchronous reset mid-TRACK, then stays idle without clear/load.
    pulse_reset("rst_mid");
    step("post_rst", 1'b1, 1'b0, 5'h09, 5'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 5'h00);
    drain();

    // Two mismatches: exp 1E/obs 05, then exp 07/obs 11.
    step("cap_clr",  1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'h00);
    step("cap_load", 1'b1, 1'b1, 5'h1E, 5'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'h1E);
    step("cap_m1",   1'b1, 1'b0, 5'h00, 5'h05, 1'b1, 1'b1, 1'b1, 8'h01, 5'h06);
    step("cap_ok",   1'b1, 1'b0, 5'h00, 5'h06, 1'b1, 1'b0, 1'b1, 8'h01, 5'h07);
    step("cap_m2",   1'b1, 1'b0, 5'h00, 5'h11, 1'b1, 1'b1, 1'b1, 8'h02, 5'h12);
    drain();
`ifdef COUNTER_CHECKER_CAPTURE_EN
    check("cap.first_exp", 32'(first_exp), 32'h1E);
    check("cap.first_obs", 32'(first_obs), 32'h05);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_counter_checker
